// File: rtl/combat_pkg.sv
// Shared encodings and damage table for the fighter hit-resolution logic.
package combat_pkg;

  localparam int unsigned DAMAGE_W = 8;
  localparam int unsigned TIMER_W  = 8;

  typedef enum logic [1:0] {
    PS_VULN   = 2'd0,
    PS_STUN   = 2'd1,
    PS_INVULN = 2'd2
  } player_state_e;

  localparam logic [3:0] ANIM_NEUTRAL = 4'd6;
  localparam logic [3:0] ANIM_SIDE    = 4'd7;
  localparam logic [3:0] ANIM_UP      = 4'd8;
  localparam logic [3:0] ANIM_DOWN    = 4'd9;

  localparam logic [DAMAGE_W-1:0] DMG_NEUTRAL = 8'd3;
  localparam logic [DAMAGE_W-1:0] DMG_SIDE    = 8'd5;
  localparam logic [DAMAGE_W-1:0] DMG_UP      = 8'd4;
  localparam logic [DAMAGE_W-1:0] DMG_DOWN    = 8'd6;
  localparam logic [DAMAGE_W-1:0] DMG_OTHER   = 8'd1;

  function automatic logic [DAMAGE_W-1:0] damage_lookup(input logic [3:0] anim);
    case (anim)
      ANIM_NEUTRAL: damage_lookup = DMG_NEUTRAL;
      ANIM_SIDE:    damage_lookup = DMG_SIDE;
      ANIM_UP:      damage_lookup = DMG_UP;
      ANIM_DOWN:    damage_lookup = DMG_DOWN;
      default:      damage_lookup = DMG_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/fighter_hit_state.sv
// One player's VULN/STUN/INVULN sequencer, frame timer, saturating damage
// accumulator and hit pulse.
module fighter_hit_state
  import combat_pkg::*;
#(
  parameter int unsigned          StunFrames   = 12,
  parameter int unsigned          InvulnFrames = 20,
  parameter logic [DAMAGE_W-1:0]  DamageMax    = 8'd255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                frame_tick_i,
  input  logic                round_reset_i,
  input  logic                hit_landed_i,
  input  logic [DAMAGE_W-1:0] dmg_amount_i,
  output logic                stun_o,
  output logic                invuln_o,
  output logic [DAMAGE_W-1:0] damage_o,
  output logic                hit_pulse_o
);

  localparam logic [TIMER_W-1:0] StunInit   = TIMER_W'(StunFrames);
  localparam logic [TIMER_W-1:0] InvulnInit = TIMER_W'(InvulnFrames);
  localparam logic [TIMER_W-1:0] TimerOne   = TIMER_W'(1);

  player_state_e       state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [DAMAGE_W-1:0] damage_q, damage_d;
  logic                pulse_q, pulse_d;

  logic [DAMAGE_W:0]   dmg_sum;
  logic [DAMAGE_W-1:0] dmg_sat;

  // 9-bit sum so the carry out is visible to the saturation compare.
  assign dmg_sum = {1'b0, damage_q} + {1'b0, dmg_amount_i};
  assign dmg_sat = (dmg_sum > {1'b0, DamageMax}) ? DamageMax : dmg_sum[DAMAGE_W-1:0];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    damage_d = damage_q;
    pulse_d  = 1'b0;
    if (round_reset_i) begin
      state_d  = PS_VULN;
      timer_d  = '0;
      damage_d = '0;
    end else if (frame_tick_i) begin
      case (state_q)
        PS_VULN: begin
          if (hit_landed_i) begin
            pulse_d  = 1'b1;
            damage_d = dmg_sat;
            // Zero-length phases are skipped on the hit tick itself.
            if (StunFrames != 0) begin
              state_d = PS_STUN;
              timer_d = StunInit;
            end else if (InvulnFrames != 0) begin
              state_d = PS_INVULN;
              timer_d = InvulnInit;
            end
          end
        end
        PS_STUN: begin
          if (timer_q <= TimerOne) begin
            if (InvulnFrames != 0) begin
              state_d = PS_INVULN;
              timer_d = InvulnInit;
            end else begin
              state_d = PS_VULN;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        PS_INVULN: begin
          if (timer_q <= TimerOne) begin
            state_d = PS_VULN;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TimerOne;
          end
        end
        default: begin
          state_d = PS_VULN;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= PS_VULN;
      timer_q  <= '0;
      damage_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      damage_q <= damage_d;
      pulse_q  <= pulse_d;
    end
  end

  assign stun_o      = (state_q == PS_STUN);
  assign invuln_o    = (state_q == PS_INVULN);
  assign damage_o    = damage_q;
  assign hit_pulse_o = pulse_q;

endmodule

// File: rtl/combat_arbiter.sv
// Per-frame hit resolution between two fighters: qualifies hits, tracks
// one-hit-per-swing connected flags and feeds each player's hit sequencer.
module combat_arbiter
  import combat_pkg::*;
#(
  parameter int unsigned         STUN_FRAMES   = 12,
  parameter int unsigned         INVULN_FRAMES = 20,
  parameter logic [DAMAGE_W-1:0] DAMAGE_MAX    = 8'd255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                round_reset,
  input  logic                p1_attack_active,
  input  logic [3:0]          p1_anim_state,
  input  logic                p2_attack_active,
  input  logic [3:0]          p2_anim_state,
  input  logic                p1_hits_p2,
  input  logic                p2_hits_p1,
  output logic                p1_hit_stun_active,
  output logic                p2_hit_stun_active,
  output logic                p1_invuln,
  output logic                p2_invuln,
  output logic [DAMAGE_W-1:0] p1_damage,
  output logic [DAMAGE_W-1:0] p2_damage,
  output logic                p1_hit_pulse,
  output logic                p2_hit_pulse
);

  logic p1_conn_q, p1_conn_d;
  logic p2_conn_q, p2_conn_d;
  logic p1_lands, p2_lands;
  logic p1_vuln, p2_vuln;

  assign p1_vuln = ~p1_hit_stun_active & ~p1_invuln;
  assign p2_vuln = ~p2_hit_stun_active & ~p2_invuln;

  // All qualifiers come from registered state, so mutual hits on one tick trade.
  assign p1_lands = p1_attack_active & ~p1_conn_q & p1_hits_p2 & p2_vuln & ~p1_hit_stun_active;
  assign p2_lands = p2_attack_active & ~p2_conn_q & p2_hits_p1 & p1_vuln & ~p2_hit_stun_active;

  always_comb begin
    p1_conn_d = p1_conn_q;
    p2_conn_d = p2_conn_q;
    if (round_reset) begin
      p1_conn_d = 1'b0;
      p2_conn_d = 1'b0;
    end else if (frame_tick) begin
      if (!p1_attack_active) p1_conn_d = 1'b0;
      else if (p1_lands)     p1_conn_d = 1'b1;
      if (!p2_attack_active) p2_conn_d = 1'b0;
      else if (p2_lands)     p2_conn_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_conn_q <= 1'b0;
      p2_conn_q <= 1'b0;
    end else begin
      p1_conn_q <= p1_conn_d;
      p2_conn_q <= p2_conn_d;
    end
  end

  fighter_hit_state #(
    .StunFrames   (STUN_FRAMES),
    .InvulnFrames (INVULN_FRAMES),
    .DamageMax    (DAMAGE_MAX)
  ) u_p1_state (
    .clk_i         (clk),
    .rst_ni        (reset),
    .frame_tick_i  (frame_tick),
    .round_reset_i (round_reset),
    .hit_landed_i  (p2_lands),
    .dmg_amount_i  (damage_lookup(p2_anim_state)),
    .stun_o        (p1_hit_stun_active),
    .invuln_o      (p1_invuln),
    .damage_o      (p1_damage),
    .hit_pulse_o   (p1_hit_pulse)
  );

  fighter_hit_state #(
    .StunFrames   (STUN_FRAMES),
    .InvulnFrames (INVULN_FRAMES),
    .DamageMax    (DAMAGE_MAX)
  ) u_p2_state (
    .clk_i         (clk),
    .rst_ni        (reset),
    .frame_tick_i  (frame_tick),
    .round_reset_i (round_reset),
    .hit_landed_i  (p1_lands),
    .dmg_amount_i  (damage_lookup(p1_anim_state)),
    .stun_o        (p2_hit_stun_active),
    .invuln_o      (p2_invuln),
    .damage_o      (p2_damage),
    .hit_pulse_o   (p2_hit_pulse)
  );

endmodule

// File: tb/tb_combat_arbiter.sv
// Directed bench for combat_arbiter: stun/invuln timing, one hit per swing,
// trades, saturation, round reset and async reset.
module tb_combat_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, round_reset = 1'b0;
  logic       p1_attack_active = 1'b0, p2_attack_active = 1'b0;
  logic [3:0] p1_anim_state = 4'd0, p2_anim_state = 4'd0;
  logic       p1_hits_p2 = 1'b0, p2_hits_p1 = 1'b0;
  logic       p1_hit_stun_active, p2_hit_stun_active, p1_invuln, p2_invuln;
  logic [7:0] p1_damage, p2_damage;
  logic       p1_hit_pulse, p2_hit_pulse;

  int   total = 0, bad = 0;
  int   p1_pulses = 0, p2_pulses = 0;
  logic p1_seen, p2_seen;
  logic [21:0] all_out;

  assign all_out = {p1_hit_stun_active, p2_hit_stun_active, p1_invuln, p2_invuln,
                    p1_damage, p2_damage, p1_hit_pulse, p2_hit_pulse};

  combat_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .frame_tick         (frame_tick),
    .round_reset        (round_reset),
    .p1_attack_active   (p1_attack_active),
    .p1_anim_state      (p1_anim_state),
    .p2_attack_active   (p2_attack_active),
    .p2_anim_state      (p2_anim_state),
    .p1_hits_p2         (p1_hits_p2),
    .p2_hits_p1         (p2_hits_p1),
    .p1_hit_stun_active (p1_hit_stun_active),
    .p2_hit_stun_active (p2_hit_stun_active),
    .p1_invuln          (p1_invuln),
    .p2_invuln          (p2_invuln),
    .p1_damage          (p1_damage),
    .p2_damage          (p2_damage),
    .p1_hit_pulse       (p1_hit_pulse),
    .p2_hit_pulse       (p2_hit_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (p1_hit_pulse) p1_pulses++;
    if (p2_hit_pulse) p2_pulses++;
  end

  // One frame_tick clk; pulses are captured in the clk after the tick edge.
  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); #1;
    p1_seen = p1_hit_pulse;
    p2_seen = p2_hit_pulse;
    frame_tick = 1'b0;
  endtask

  task automatic round_rst();
    @(negedge clk); round_reset = 1'b1;
    @(negedge clk); #1; round_reset = 1'b0;
  endtask

  task automatic clear_inputs();
    p1_attack_active = 0; p2_attack_active = 0; p1_hits_p2 = 0; p2_hits_p1 = 0;
  endtask

  // P2 must be vulnerable on entry; returns with P2 vulnerable again.
  task automatic swing_p1(input logic [3:0] anim);
    p1_anim_state = anim; p1_attack_active = 1; p1_hits_p2 = 1;
    tick();
    p1_attack_active = 0; p1_hits_p2 = 0;
    repeat (32) tick();
  endtask

  task automatic test_reset();
    #12;
    total++; if (all_out !== 22'd0) begin bad++; $display("FAIL reset_held got=%h want=0", all_out); end
    @(negedge clk); reset = 1'b1; #1;
    total++; if (all_out !== 22'd0) begin bad++; $display("FAIL reset_release got=%h want=0", all_out); end
  endtask

  task automatic test_single_hit();
    int stun_bad = 0, inv_bad = 0;
    p2_pulses = 0;
    p1_anim_state = 4'd7; p1_attack_active = 1; p1_hits_p2 = 1;
    tick();
    total++; if ({p1_seen, p2_seen} !== 2'b01) begin bad++; $display("FAIL hit_pulse got=%b want=01", {p1_seen, p2_seen}); end
    total++; if (p2_damage !== 8'd5) begin bad++; $display("FAIL side_damage got=%0d want=5", p2_damage); end
    clear_inputs();
    repeat (5) @(negedge clk);
    #1;
    total++; if (p2_pulses !== 1) begin bad++; $display("FAIL pulse_width got=%0d want=1", p2_pulses); end
    total++; if ({p2_hit_stun_active, p2_damage} !== {1'b1, 8'd5}) begin bad++; $display("FAIL no_tick_hold got=%b/%0d want=1/5", p2_hit_stun_active, p2_damage); end
    for (int i = 0; i < 11; i++) begin tick(); if (!p2_hit_stun_active) stun_bad++; end
    total++; if (stun_bad !== 0) begin bad++; $display("FAIL stun_length got=%0d early exits want=0", stun_bad); end
    tick();
    total++; if ({p2_hit_stun_active, p2_invuln} !== 2'b01) begin bad++; $display("FAIL stun_to_invuln got=%b want=01", {p2_hit_stun_active, p2_invuln}); end
    for (int i = 0; i < 19; i++) begin tick(); if (!p2_invuln) inv_bad++; end
    total++; if (inv_bad !== 0) begin bad++; $display("FAIL invuln_length got=%0d early exits want=0", inv_bad); end
    tick();
    total++; if ({p2_hit_stun_active, p2_invuln} !== 2'b00) begin bad++; $display("FAIL invuln_to_vuln got=%b want=00", {p2_hit_stun_active, p2_invuln}); end
  endtask

  task automatic test_back_to_back();
    round_rst();
    p2_pulses = 0;
    p1_anim_state = 4'd7; p1_attack_active = 1; p1_hits_p2 = 1;
    repeat (10) tick();
    total++; if (p2_pulses !== 1 || p2_damage !== 8'd5) begin bad++; $display("FAIL held_swing got=%0d/%0d want=1/5", p2_pulses, p2_damage); end
    p1_attack_active = 0;
    tick();
    p1_attack_active = 1;
    repeat (22) tick();
    total++; if (p2_pulses !== 1) begin bad++; $display("FAIL hit_while_protected got=%0d want=1", p2_pulses); end
    total++; if ({p2_hit_stun_active, p2_invuln} !== 2'b00) begin bad++; $display("FAIL back_to_vuln got=%b want=00", {p2_hit_stun_active, p2_invuln}); end
    tick();
    total++; if (p2_pulses !== 2 || p2_damage !== 8'd10 || !p2_hit_stun_active) begin bad++; $display("FAIL second_swing got=%0d/%0d/%b want=2/10/1", p2_pulses, p2_damage, p2_hit_stun_active); end
    clear_inputs();
  endtask

  task automatic test_trade();
    round_rst();
    p1_anim_state = 4'd9; p2_anim_state = 4'd6;
    p1_attack_active = 1; p2_attack_active = 1; p1_hits_p2 = 1; p2_hits_p1 = 1;
    tick();
    total++; if ({p1_seen, p2_seen} !== 2'b11) begin bad++; $display("FAIL trade_pulses got=%b want=11", {p1_seen, p2_seen}); end
    total++; if (p1_damage !== 8'd3 || p2_damage !== 8'd6) begin bad++; $display("FAIL trade_damage got=%0d/%0d want=3/6", p1_damage, p2_damage); end
    total++; if ({p1_hit_stun_active, p2_hit_stun_active} !== 2'b11) begin bad++; $display("FAIL trade_stun got=%b want=11", {p1_hit_stun_active, p2_hit_stun_active}); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    round_rst();
    p2_pulses = 0;
    repeat (42) swing_p1(4'd9);
    swing_p1(4'd0);
    total++; if (p2_damage !== 8'd253) begin bad++; $display("FAIL accumulate got=%0d want=253", p2_damage); end
    swing_p1(4'd9);
    total++; if (p2_damage !== 8'd255) begin bad++; $display("FAIL saturate got=%0d want=255", p2_damage); end
    swing_p1(4'd8);
    total++; if (p2_damage !== 8'd255 || p2_pulses !== 45) begin bad++; $display("FAIL stay_saturated got=%0d/%0d want=255/45", p2_damage, p2_pulses); end
  endtask

  task automatic test_invuln_and_round_reset();
    round_rst();
    p2_pulses = 0;
    p1_anim_state = 4'd6; p1_attack_active = 1; p1_hits_p2 = 1;
    tick();
    p1_attack_active = 0;
    repeat (12) tick();
    p1_attack_active = 1;
    tick();
    total++; if (p2_seen !== 1'b0 || p2_pulses !== 1 || p2_damage !== 8'd3 || !p2_invuln) begin bad++; $display("FAIL invuln_ignores got=%b/%0d/%0d/%b want=0/1/3/1", p2_seen, p2_pulses, p2_damage, p2_invuln); end
    round_rst();
    total++; if (all_out !== 22'd0) begin bad++; $display("FAIL round_reset_clear got=%h want=0", all_out); end
    tick();
    total++; if (!p2_hit_stun_active || p2_damage !== 8'd3) begin bad++; $display("FAIL hit_after_round got=%b/%0d want=1/3", p2_hit_stun_active, p2_damage); end
    @(negedge clk); round_reset = 1; frame_tick = 1;
    @(negedge clk); #1; round_reset = 0; frame_tick = 0;
    total++; if (all_out !== 22'd0) begin bad++; $display("FAIL round_reset_priority got=%h want=0", all_out); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    int pulses_before;
    round_rst();
    p1_anim_state = 4'd7; p1_attack_active = 1; p1_hits_p2 = 1;
    tick();
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    total++; if (!p2_hit_stun_active) begin bad++; $display("FAIL pre_async_stun got=%b want=1", p2_hit_stun_active); end
    pulses_before = p2_pulses;
    @(posedge clk); #2 reset = 1'b0; #1;
    total++; if (all_out !== 22'd0) begin bad++; $display("FAIL async_reset got=%h want=0", all_out); end
    @(negedge clk); #1 reset = 1'b1;
    total++; if (p2_pulses !== pulses_before) begin bad++; $display("FAIL async_no_pulse got=%0d want=%0d", p2_pulses, pulses_before); end
    p1_attack_active = 1; p1_hits_p2 = 1;
    tick();
    total++; if (p2_seen !== 1'b1 || p2_damage !== 8'd5 || !p2_hit_stun_active) begin bad++; $display("FAIL hit_after_async got=%b/%0d/%b want=1/5/1", p2_seen, p2_damage, p2_hit_stun_active); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_back_to_back();
    test_trade();
    test_saturation();
    test_invuln_and_round_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/combat_arbiter.md
Name: combat_arbiter

Overview:
Per-frame hit resolution between the two fighters' attack FSMs. Consumes each player's attack_active/anim_state plus hitbox-overlap flags from collision logic. Decides which hits land, applies damage, and drives each player's hit_stun_active back into that player's attack FSM. Also sequences stun and invulnerability windows, so each swing connects at most once and simultaneous hits resolve deterministically.

Parameters:
STUN_FRAMES, 12, frames a victim stays in hit-stun after a landed hit
INVULN_FRAMES, 20, invulnerable frames following stun
DAMAGE_MAX, 8'd255, saturation ceiling for accumulated damage

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
frame_tick  in  1  one-clk pulse per video frame; all state advances only on it
round_reset  in  1  synchronous; clears damage and per-player state on any clk edge
p1_attack_active  in  1  from P1 attack FSM
p1_anim_state  in  4  from P1 attack FSM (6 neutral, 7 side, 8 up, 9 down)
p2_attack_active  in  1  from P2 attack FSM
p2_anim_state  in  4  from P2 attack FSM
p1_hits_p2  in  1  P1 hitbox overlaps P2 hurtbox this frame
p2_hits_p1  in  1  P2 hitbox overlaps P1 hurtbox this frame
p1_hit_stun_active  out  1  P1 in STUN (to P1 attack FSM)
p2_hit_stun_active  out  1  P2 in STUN
p1_invuln  out  1  P1 in INVULN (sprite flicker)
p2_invuln  out  1  P2 in INVULN
p1_damage  out  8  accumulated damage on P1
p2_damage  out  8  accumulated damage on P2
p1_hit_pulse  out  1  one-clk pulse when P1 is hit
p2_hit_pulse  out  1  one-clk pulse when P2 is hit

Behaviour:
- Reset (reset low, async): all outputs 0; both players VULN; timers 0; connected flags 0.
- Per-player states: VULN=0, STUN=1, INVULN=2. State outputs are decoded from registered state.
- A hit on victim V by attacker A lands on a frame_tick when all hold: A_attack_active=1, A's connected flag=0, overlap(A->V)=1, V in VULN, A not in STUN. All terms are sampled from pre-tick registered state.
- Simultaneous hits: evaluation uses pre-tick state, so mutual hits on the same tick both land (trade). Both players enter STUN, both take damage, and both pulses fire.
- Landed hit: V goes to STUN with timer=STUN_FRAMES; V_damage += table(A_anim_state); V_hit_pulse=1 for the clk after the tick; A's connected flag is set. Latency: hit_stun_active is high from the clk edge after the evaluating tick.
- Damage table: 6->3, 7->5, 8->4, 9->6, any other->1. Addition is 9-bit, saturating at DAMAGE_MAX.
- Connected flag: cleared on any tick where A_attack_active=0. One swing never lands twice.
- STUN: decrements on each tick. On the tick where timer==1, go to INVULN with timer=INVULN_FRAMES.
- INVULN: decrements on each tick. On the tick where timer==1, go to VULN. Hits are ignored in INVULN, with no pulse and no damage.
- STUN_FRAMES=0 or INVULN_FRAMES=0: that phase is skipped, with the transition taken directly on the hit tick.
- No frame_tick: state, timers and damage hold; pulses stay 0.
- round_reset has priority over frame_tick in the same clk. All state returns to reset values, and any in-progress stun is cancelled.
- Async reset mid-stun: immediate return to reset values; no pulse is emitted.

Decomposition:
- Package combat_pkg holds: state encodings (PS_VULN/PS_STUN/PS_INVULN, 2-bit), attack anim_state codes 6-9, damage-table constants, DAMAGE_W=8.
- Sub-module fighter_hit_state, instantiated twice, holds one player's state, timer, saturating damage accumulator and pulse register. Inputs: hit_landed, dmg_amount.
- The top level holds hit qualification, the connected flags and the damage lookup.

Test Plan:
1. P1 side attack (anim 7) overlapping P2 for 1 tick -> p2_hit_pulse one clk; p2_damage=5; p2_hit_stun_active high for exactly 12 ticks, then p2_invuln for 20 ticks, then VULN.
2. P1 attack held active with overlap for 10 ticks -> exactly one hit. After attack_active drops then rises again, a new overlap lands only once P2 is back in VULN.
3. Both attack (P1 anim 9, P2 anim 6) with mutual overlap on the same tick -> both stunned; p1_damage=3, p2_damage=6; both pulses in the same clk.
4. P2 at damage 253, hit by down attack (6) -> p2_damage saturates at 255; a further hit keeps 255.
5. Overlap during P2 INVULN -> no pulse and damage unchanged. round_reset asserted during STUN -> all outputs 0 on the next clk.
6. reset driven low mid-stun, between clk edges -> outputs 0 immediately. After release, a hit lands normally on the first qualifying tick.
